// File: rtl/mem_pkg.sv
// Shared definitions for the program/data memory: default program image,
// CPU opcode values and the init sequencer state type.
package mem_pkg;

    localparam logic [7:0] OP_LD   = 8'h10;
    localparam logic [7:0] OP_ADD  = 8'h11;
    localparam logic [7:0] OP_SUB  = 8'h12;
    localparam logic [7:0] OP_AND  = 8'h13;
    localparam logic [7:0] OP_OR   = 8'h14;
    localparam logic [7:0] OP_STO  = 8'h15;
    localparam logic [7:0] OP_HALT = 8'h16;

    localparam logic [7:0] DEFAULT_PROG [16] = '{
        8'h10, 8'h05, 8'h11, 8'h06, 8'h12, 8'h07, 8'h13, 8'h08,
        8'h14, 8'h09, 8'h11, 8'h06, 8'h12, 8'h07, 8'h13, 8'h08
    };

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Program image beyond the 16-word table reads as zero.
    function automatic logic [7:0] default_word(input logic [31:0] idx);
        logic [7:0] w;
        w = 8'h00;
        if (idx < 32'd16) begin
            w = DEFAULT_PROG[idx[3:0]];
        end
        return w;
    endfunction

endpackage

// File: rtl/mem_init_seq.sv
// Reset-driven init walker: writes one word per cycle from address 0 up to
// DEPTH-1, then hands the memory over to the core.
module mem_init_seq
    import mem_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int INIT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic [DATA_W-1:0] init_data,
    output state_t            state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

    // One extra bit so the pointer can sit at DEPTH once the walk is done.
    logic [ADDR_W:0] init_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= INIT;
            init_ptr <= '0;
            busy     <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + 1'b1;
                    if (init_ptr == LAST) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    busy <= 1'b0;
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

    assign init_we   = (state == INIT) && !rst;
    assign init_addr = init_ptr[ADDR_W-1:0];
    assign init_data = (INIT_MODE == 0) ? '0 : DATA_W'(default_word(32'(init_ptr)));

endmodule

// File: rtl/prog_data_mem.sv
// Program/data memory with a fetch read port, a data read/write port,
// registered reads with write-first bypass, and an init walk after reset.
module prog_data_mem
    import mem_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int INIT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_en,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_data,
    output logic              if_valid,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              req_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              init_we;
    logic [ADDR_W-1:0] init_addr;
    logic [DATA_W-1:0] init_data;
    state_t            seq_state;
    logic              run;

    mem_init_seq #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_MODE (INIT_MODE)
    ) u_init_seq (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data),
        .state     (seq_state)
    );

    assign run = (seq_state == RUN);

    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end else if (run && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Request/valid: a request (if_en, rd_en, wr_en) is accepted on an edge
    // where busy is low. An accepted read raises its valid for exactly the
    // following cycle with the data; a request seen while busy is dropped and
    // reported by a one-cycle req_drop. There is no backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_data  <= '0;
            if_valid <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            req_drop <= 1'b0;
        end else begin
            req_drop <= !run && (if_en || rd_en || wr_en);
            if_valid <= run && if_en;
            rd_valid <= run && rd_en;
            if (run && if_en) begin
                if_data <= (wr_en && (wr_addr == if_addr)) ? wr_data : mem[if_addr];
            end
            if (run && rd_en) begin
                rd_data <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_prog_data_mem.sv
// Bench for prog_data_mem: a program-loaded 16-word instance and a
// zero-filled 32-word instance, checked against a behavioural model.
module tb_prog_data_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance a: ADDR_W=4, INIT_MODE=1
    logic       rst_a = 1'b1, if_en_a = 1'b0, rd_en_a = 1'b0, wr_en_a = 1'b0;
    logic [3:0] if_addr_a = '0, rd_addr_a = '0, wr_addr_a = '0;
    logic [7:0] wr_data_a = '0, if_data_a, rd_data_a;
    logic       if_valid_a, rd_valid_a, busy_a, req_drop_a;

    // instance b: ADDR_W=5, INIT_MODE=0
    logic       rst_b = 1'b1, if_en_b = 1'b0, rd_en_b = 1'b0, wr_en_b = 1'b0;
    logic [4:0] if_addr_b = '0, rd_addr_b = '0, wr_addr_b = '0;
    logic [7:0] wr_data_b = '0, if_data_b, rd_data_b;
    logic       if_valid_b, rd_valid_b, busy_b, req_drop_b;

    prog_data_mem #(.DATA_W(8), .ADDR_W(4), .INIT_MODE(1)) dut_a (
        .clk(clk), .rst(rst_a),
        .if_en(if_en_a), .if_addr(if_addr_a), .if_data(if_data_a), .if_valid(if_valid_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .busy(busy_a), .req_drop(req_drop_a)
    );

    prog_data_mem #(.DATA_W(8), .ADDR_W(5), .INIT_MODE(0)) dut_b (
        .clk(clk), .rst(rst_b),
        .if_en(if_en_b), .if_addr(if_addr_b), .if_data(if_data_b), .if_valid(if_valid_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .req_drop(req_drop_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] prog [16] = '{
        8'h10, 8'h05, 8'h11, 8'h06, 8'h12, 8'h07, 8'h13, 8'h08,
        8'h14, 8'h09, 8'h11, 8'h06, 8'h12, 8'h07, 8'h13, 8'h08
    };
    logic [7:0] mm [2][32];
    int         cnt [2];
    logic [7:0] e_if_data [2], e_rd_data [2];
    logic       e_if_valid [2], e_rd_valid [2], e_busy [2], e_drop [2];
    bit         model_ready = 0;

    task automatic model_step(input int d, input int depth, input int mode, input logic rst,
                              input logic if_en, input int if_addr, input logic rd_en,
                              input int rd_addr, input logic wr_en, input int wr_addr,
                              input logic [7:0] wr_data);
        if (rst) begin
            cnt[d] = 0;
            e_if_data[d] = 8'h00; e_rd_data[d] = 8'h00;
            e_if_valid[d] = 0; e_rd_valid[d] = 0; e_drop[d] = 0; e_busy[d] = 1;
        end else if (cnt[d] < depth) begin
            mm[d][cnt[d]] = (mode == 1 && cnt[d] < 16) ? prog[cnt[d]] : 8'h00;
            e_drop[d] = if_en | rd_en | wr_en;
            e_if_valid[d] = 0; e_rd_valid[d] = 0;
            cnt[d] = cnt[d] + 1;
            e_busy[d] = (cnt[d] < depth);
        end else begin
            // write-first: commit the write, then both reads see it
            if (wr_en) mm[d][wr_addr] = wr_data;
            e_if_valid[d] = if_en;
            e_rd_valid[d] = rd_en;
            if (if_en) e_if_data[d] = mm[d][if_addr];
            if (rd_en) e_rd_data[d] = mm[d][rd_addr];
            e_drop[d] = 0; e_busy[d] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, 16, 1, rst_a, if_en_a, int'(if_addr_a), rd_en_a, int'(rd_addr_a),
                   wr_en_a, int'(wr_addr_a), wr_data_a);
        model_step(1, 32, 0, rst_b, if_en_b, int'(if_addr_b), rd_en_b, int'(rd_addr_b),
                   wr_en_b, int'(wr_addr_b), wr_data_b);
        model_ready = 1;
    end

    // compare process: every output of both instances, every cycle
    always @(negedge clk) begin
        if (model_ready) begin
            check("a_if_data",  if_data_a,  e_if_data[0]);
            check("a_if_valid", if_valid_a, e_if_valid[0]);
            check("a_rd_data",  rd_data_a,  e_rd_data[0]);
            check("a_rd_valid", rd_valid_a, e_rd_valid[0]);
            check("a_busy",     busy_a,     e_busy[0]);
            check("a_req_drop", req_drop_a, e_drop[0]);
            check("b_if_data",  if_data_b,  e_if_data[1]);
            check("b_if_valid", if_valid_b, e_if_valid[1]);
            check("b_rd_data",  rd_data_b,  e_rd_data[1]);
            check("b_rd_valid", rd_valid_b, e_rd_valid[1]);
            check("b_busy",     busy_b,     e_busy[1]);
            check("b_req_drop", req_drop_b, e_drop[1]);
        end
    end

    // ---------------- driver ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a;
        if_en_a = 0; rd_en_a = 0; wr_en_a = 0;
    endtask

    // release rst_a and walk the init, pinning busy on edges 15 and 16
    task automatic release_a;
        rst_a = 0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            if (e == 15) check("a_busy_edge15", busy_a, 1'b1);
            if (e == 16) check("a_busy_edge16", busy_a, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("a_reset_busy", busy_a, 1'b1);
        check("a_reset_if_data", if_data_a, 8'h00);

        // release with a dropped write + read during the first init cycle
        rst_a = 0;
        wr_en_a = 1; wr_addr_a = 4'h2; wr_data_a = 8'hFF; rd_en_a = 1; rd_addr_a = 4'h2;
        tick();
        check("a_init_req_drop", req_drop_a, 1'b1);
        check("a_init_rd_valid", rd_valid_a, 1'b0);
        idle_a();
        for (int e = 2; e <= 16; e++) begin
            tick();
            if (e == 15) check("a_busy_edge15", busy_a, 1'b1);
            if (e == 16) check("a_busy_edge16", busy_a, 1'b0);
        end

        // fetch the whole default program
        for (int a = 0; a < 16; a++) begin
            if_en_a = 1; if_addr_a = 4'(a);
            tick();
            check("a_fetch_data", if_data_a, prog[a]);
            check("a_fetch_valid", if_valid_a, 1'b1);
        end
        idle_a();

        // write-first bypass, then fetch the written word
        wr_en_a = 1; wr_addr_a = 4'h3; wr_data_a = 8'hA5; rd_en_a = 1; rd_addr_a = 4'h3;
        tick();
        check("a_bypass_rd", rd_data_a, 8'hA5);
        idle_a();
        if_en_a = 1; if_addr_a = 4'h3;
        tick();
        check("a_after_wr_if", if_data_a, 8'hA5);
        idle_a();

        // write dropped during init did not land
        rd_en_a = 1; rd_addr_a = 4'h2;
        tick();
        check("a_addr2_kept", rd_data_a, 8'h11);
        idle_a();

        // both ports in the same cycle
        if_en_a = 1; if_addr_a = 4'h4; rd_en_a = 1; rd_addr_a = 4'h9;
        tick();
        check("a_dual_if", if_data_a, 8'h12);
        check("a_dual_rd", rd_data_a, 8'h09);
        check("a_dual_valid", {if_valid_a, rd_valid_a}, 2'b11);
        idle_a();

        // both ports bypass the same written address
        wr_en_a = 1; wr_addr_a = 4'h7; wr_data_a = 8'h3C;
        if_en_a = 1; if_addr_a = 4'h7; rd_en_a = 1; rd_addr_a = 4'h7;
        tick();
        check("a_dual_bypass_if", if_data_a, 8'h3C);
        check("a_dual_bypass_rd", rd_data_a, 8'h3C);
        idle_a();
        tick();
        check("a_hold_data", rd_data_a, 8'h3C);
        check("a_hold_valid", rd_valid_a, 1'b0);

        // dirty two words, then reset mid-init at init_ptr = 7
        wr_en_a = 1; wr_addr_a = 4'h0; wr_data_a = 8'h77;
        tick();
        wr_addr_a = 4'hA; wr_data_a = 8'h5A;
        tick();
        idle_a();
        rst_a = 1;
        tick();
        check("a_rst_rd_valid", rd_valid_a, 1'b0);
        check("a_rst_rd_data", rd_data_a, 8'h00);
        rst_a = 0;
        for (int e = 0; e < 7; e++) tick();
        rst_a = 1;
        tick();
        release_a();
        for (int a = 0; a < 16; a++) begin
            if_en_a = 1; if_addr_a = 4'(a);
            rd_en_a = 1; rd_addr_a = 4'(15 - a);
            tick();
            check("a_reinit_if", if_data_a, prog[a]);
            check("a_reinit_rd", rd_data_a, prog[15 - a]);
        end
        idle_a();

        // instance b: zero-fill, 32 busy edges, dropped write during init
        rst_b = 0;
        wr_en_b = 1; wr_addr_b = 5'h10; wr_data_b = 8'hC3;
        for (int e = 1; e <= 32; e++) begin
            tick();
            if (e == 1) begin
                check("b_init_req_drop", req_drop_b, 1'b1);
                wr_en_b = 0;
            end
            if (e == 31) check("b_busy_edge31", busy_b, 1'b1);
            if (e == 32) check("b_busy_edge32", busy_b, 1'b0);
        end
        rd_en_b = 1; rd_addr_b = 5'h00;
        tick();
        check("b_rd_00", rd_data_b, 8'h00);
        check("b_rd_00_valid", rd_valid_b, 1'b1);
        rd_addr_b = 5'h10; wr_en_b = 1; wr_addr_b = 5'h1F; wr_data_b = 8'h9E;
        tick();
        check("b_rd_10", rd_data_b, 8'h00);
        wr_en_b = 0; rd_addr_b = 5'h1F; if_en_b = 1; if_addr_b = 5'h1E;
        tick();
        check("b_rd_1f_written", rd_data_b, 8'h9E);
        check("b_if_1e", if_data_b, 8'h00);
        rd_en_b = 0; if_en_b = 0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_data_mem.md
# prog_data_mem

Parametrised synchronous program/data memory for the 8-bit CPU, replacing the fixed 16×8 combinational store. It offers an instruction-fetch read port and a data read/write port, one-cycle registered reads, write-first collision rules, and a reset-driven init sequencer. The sequencer loads either the default test program or zeros into every word before the core is allowed in. It sits between the control unit (fetch/operand reads, STO writes) and nothing else.

## Interface
Parameters:
- DATA_W, 8, word width
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W (derived, not overridable)
- INIT_MODE, 1, 0 = zero-fill, 1 = load default program

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- if_en  in  1  instruction-fetch request
- if_addr  in  ADDR_W  fetch address
- if_data  out  DATA_W  fetched word
- if_valid  out  1  if_data valid this cycle
- rd_en  in  1  data read request
- rd_addr  in  ADDR_W  data read address
- rd_data  out  DATA_W  read word
- rd_valid  out  1  rd_data valid this cycle
- wr_en  in  1  data write request, active-high
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write word
- busy  out  1  init in progress; requests not accepted
- req_drop  out  1  one-cycle pulse: a request arrived while busy and was discarded

## Operation
- States: INIT, RUN. rst forces INIT with init_ptr = 0 from any state, including mid-init.
- INIT: each edge with rst=0 writes init_word(init_ptr) to mem[init_ptr], then init_ptr += 1. After the edge that writes DEPTH-1, go to RUN. init_ptr does not wrap.
- init_word: INIT_MODE=0 gives 0. INIT_MODE=1 gives DEFAULT_PROG[i] for i < 16 and 0 for i ≥ 16. For ADDR_W < 4, the first DEPTH entries are loaded.
- DEFAULT_PROG, addr 0..F: 10,05,11,06,12,07,13,08,14,09,11,06,12,07,13,08 (hex).
- In INIT, if_en, rd_en and wr_en are ignored. No memory change from wr_en. if_valid and rd_valid stay 0. req_drop = 1 on the next edge if any of them was high.
- RUN, write: wr_en=1 gives mem[wr_addr] ← wr_data at the edge.
- RUN, reads: rd_en=1 gives rd_data ← mem[rd_addr] and rd_valid ← 1 at the edge. if_en works the same way on the fetch port, independently. Without a request, valid ← 0 and data holds its last value.
- Collision: a read (either port) to the address written in the same cycle returns wr_data (write-first). Both read ports may hit the same address in the same cycle.
- All widths are exact. There is no address arithmetic outside the init pointer (ADDR_W+1 bits, so it can hold DEPTH).

## Timing
- Reset values: if_data = 0, rd_data = 0, if_valid = 0, rd_valid = 0, req_drop = 0, busy = 1.
- busy = 1 while rst is high. After rst is released, busy stays 1 for exactly DEPTH edges.
- The first request is accepted on edge DEPTH+1 after release (counting the first edge with rst=0 as edge 1).
- Read latency is 1 cycle: request at edge N, data and valid visible after edge N. Back-to-back reads give one result per cycle.
- Write latency: the word is visible to a read issued in the same cycle (bypass) and to any later read.
- busy and req_drop are registered. Memory contents are undefined during rst and after rst until the init walk covers the address.

## Structure
- Package mem_pkg: DEFAULT_PROG constant array (16 × 8), opcode localparams (LD=10, ADD=11, SUB=12, AND=13, OR=14, STO=15, HALT=16), state enum {INIT, RUN}.
- Sub-module mem_init_seq holds the INIT/RUN FSM, init_ptr, busy, and init write address/data. The top level owns the array, port muxing and bypass.

## Test plan
- Reset release, INIT_MODE=1, ADDR_W=4 -> busy high for 16 edges. Then if_en at addr 0..F returns 10,05,11,06,…,13,08 with if_valid one cycle later.
- INIT_MODE=0, ADDR_W=5 -> after 32 busy edges, reads of addr 0x00, 0x10 and 0x1F all return 00.
- RUN: wr_en addr 3 data A5 with rd_en addr 3 in the same cycle -> rd_data = A5 next cycle. if_en addr 3 the following cycle -> if_data = A5.
- During INIT: wr_en addr 2 data FF plus rd_en -> req_drop pulses, rd_valid = 0. After init, addr 2 reads 11.
- Reset asserted at init_ptr = 7 -> init restarts from 0 with busy held for a full DEPTH edges after the new release. Contents match DEFAULT_PROG.
- Simultaneous if_en addr 4 and rd_en addr 9 with no write -> if_data = 12, rd_data = 09, both valid the same cycle.
